// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a req/gnt/rvalid bus access.
// Optional macro MISALIGN_TRAP_EN flags misaligned H/W accesses instead of issuing them.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  mask_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [31:0] load_data_out,
  output logic        mem_stall_out,
  output logic        bus_err_out,
  output logic        misalign_out
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]     load_data_q, load_data_d;
  logic            bus_err_q, bus_err_d;

  logic        access, is_load, is_store;
  logic        size_byte, size_half, load_unsigned;
  logic [1:0]  off;
  logic        misalign;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_fmt;

  // A simultaneous read and write is treated as a read.
  assign access        = mem_read_in | mem_write_in;
  assign is_load       = mem_read_in;
  assign is_store      = mem_write_in & ~mem_read_in;
  assign off           = alu_result_in[1:0];
  assign size_byte     = (mask_in[1:0] == 2'b00);
  assign size_half     = (mask_in[1:0] == 2'b01);
  assign load_unsigned = mask_in[2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = access & ((size_half & off[0]) | (~size_byte & ~size_half & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Fires on the last permitted WAIT cycle; TIMEOUT_CYCLES == 0 disables it.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(wait_cnt_q) + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    be    = 4'b1111;
    wdata = write_data_in;
    if (size_byte) begin
      be    = 4'b0001 << off;
      wdata = {4{write_data_in[7:0]}};
    end else if (size_half) begin
      be    = off[1] ? 4'b1100 : 4'b0011;
      wdata = {2{write_data_in[15:0]}};
    end
    if (!access) begin
      be = 4'b0000;
    end
  end

  always_comb begin
    unique case (off)
      2'd0:    load_byte = dbus_rdata_i[7:0];
      2'd1:    load_byte = dbus_rdata_i[15:8];
      2'd2:    load_byte = dbus_rdata_i[23:16];
      default: load_byte = dbus_rdata_i[31:24];
    endcase
    load_half = off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    if (size_byte) begin
      load_fmt = {{24{load_byte[7] & ~load_unsigned}}, load_byte};
    end else if (size_half) begin
      load_fmt = {{16{load_half[15] & ~load_unsigned}}, load_half};
    end else begin
      load_fmt = dbus_rdata_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    load_data_d   = load_data_q;
    bus_err_d     = 1'b0;
    dbus_req_o    = 1'b0;
    mem_stall_out = 1'b0;
    misalign_out  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (misalign) begin
          misalign_out = 1'b1;
          load_data_d  = '0;
        end else if (access) begin
          dbus_req_o    = 1'b1;
          // A store granted immediately retires without stalling.
          mem_stall_out = ~(is_store & dbus_gnt_i);
          if (dbus_gnt_i) begin
            state_d = is_load ? StWait : StIdle;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        dbus_req_o    = 1'b1;
        mem_stall_out = 1'b1;
        if (dbus_gnt_i) begin
          state_d = is_load ? StWait : StDone;
        end
      end
      StWait: begin
        mem_stall_out = 1'b1;
        wait_cnt_d    = wait_cnt_q + CntW'(1);
        if (dbus_rvalid_i) begin
          load_data_d = load_fmt;
          state_d     = StDone;
        end else if (timeout_hit) begin
          load_data_d = '0;
          bus_err_d   = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (!reset) begin
      dbus_req_o    = 1'b0;
      mem_stall_out = 1'b0;
      misalign_out  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign dbus_we_o     = is_store;
  assign dbus_addr_o   = {alu_result_in[31:2], 2'b00};
  assign dbus_be_o     = be;
  assign dbus_wdata_o  = wdata;
  assign load_data_out = load_data_q;
  assign bus_err_out   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver acts as EX/MEM plus bus slave and queues
// expected bus requests and retire results; an independent monitor compares at each event.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [2:0]  mask_in = '0;
  logic [31:0] alu_result_in = '0, write_data_in = '0;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i = 1'b0, dbus_rvalid_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic [31:0] load_data_out;
  logic        mem_stall_out, bus_err_out, misalign_out;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .mask_in       (mask_in),
    .alu_result_in (alu_result_in),
    .write_data_in (write_data_in),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .load_data_out (load_data_out),
    .mem_stall_out (mem_stall_out),
    .bus_err_out   (bus_err_out),
    .misalign_out  (misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        err;
    logic        misal;
    int          stalls;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned acc_bytes(input logic [2:0] mask);
    case (mask)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input int unsigned v, input int unsigned bits,
                                         input bit sgn);
    int unsigned half_range = 1 << (bits - 1);
    if (sgn && v >= half_range) return v - 2 * half_range;
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] mask, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int unsigned nb = acc_bytes(mask);
    int unsigned lane = (addr % 4) / nb * nb;
    if (nb == 4) return rd;
    return extend((rd >> (8 * lane)) % (1 << (8 * nb)), 8 * nb, mask[2] == 1'b0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] mask, input logic [31:0] addr);
    int unsigned nb = acc_bytes(mask);
    int unsigned lane = (addr % 4) / nb * nb;
    return 4'(((1 << nb) - 1) << lane);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] mask, input logic [31:0] wd);
    case (acc_bytes(mask))
      1:       return (wd % 256) * 32'h0101_0101;
      2:       return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // ---------------- driver / bus slave ----------------
  task automatic issue(input bit rd, input bit wr, input logic [2:0] mask,
                       input logic [31:0] addr, input logic [31:0] wd, input int gnt_dly,
                       input int rv_dly, input bit no_rv, input logic [31:0] rdata);
    req_t rq;
    rsp_t rs;
    bit   mis = 1'b0;
    bit   granted = 1'b0, gnt_now, done;
    int   reqc = 0, since = 0;
`ifdef MISALIGN_TRAP_EN
    mis = (addr % acc_bytes(mask)) != 0;
`endif
    mem_read_in   = rd;
    mem_write_in  = wr;
    mask_in       = mask;
    alu_result_in = addr;
    write_data_in = wd;
    rs.is_load = rd;
    rs.misal   = mis;
    rs.err     = 1'b0;
    rs.data    = '0;
    rs.stalls  = 0;
    if (!mis) begin
      rq.we    = wr & ~rd;
      rq.addr  = addr & ~32'd3;
      rq.be    = model_be(mask, addr);
      rq.wdata = model_wdata(mask, wd);
      req_q.push_back(rq);
      if (rd && no_rv) begin
        rs.err    = 1'b1;
        rs.stalls = gnt_dly + int'(TO) + 1;
      end else if (rd) begin
        rs.data   = model_load(mask, addr, rdata);
        rs.stalls = gnt_dly + rv_dly + 1;
      end else begin
        rs.stalls = (gnt_dly == 0) ? 0 : gnt_dly + 1;
      end
    end
    rsp_q.push_back(rs);

    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      gnt_now       = !granted && dbus_req_o && (reqc == gnt_dly);
      if (dbus_req_o && !granted) reqc++;
      dbus_gnt_i    = gnt_now;
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i  = $urandom;
      if (granted && rd && !no_rv && since == rv_dly) begin
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = rdata;
      end else if (!granted && $urandom_range(0, 2) == 0) begin
        dbus_rvalid_i = 1'b1; // stray data before/with grant must be ignored
      end
      #1;
      done = !mem_stall_out;
      @(posedge clk);
      if (gnt_now) begin
        granted = 1'b1;
        since   = 1;
      end else if (granted) begin
        since++;
      end
      #1;
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      if (done) begin
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL retire_bound: got no retire within 60 cycles required retire at %0t", $time);
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      #1;
      mask_in       = 3'($urandom_range(0, 7));
      alu_result_in = $urandom;
      dbus_gnt_i    = 1'($urandom_range(0, 1));
      dbus_rvalid_i = 1'($urandom_range(0, 1));
      dbus_rdata_i  = $urandom;
      @(posedge clk);
      #1;
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  logic mon_acc;
  req_t mon_rq;
  rsp_t mon_rs;
  int   stall_cnt = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      stall_cnt = 0;
    end else begin
      mon_acc = mem_read_in | mem_write_in;
      if (!mon_acc) begin
        check("idle_req", 32'(dbus_req_o), 32'd0);
        check("idle_be", 32'(dbus_be_o), 32'd0);
        check("idle_bus_err", 32'(bus_err_out), 32'd0);
      end
      if (mem_stall_out) check("stall_bus_err", 32'(bus_err_out), 32'd0);
      if (dbus_req_o && dbus_gnt_i) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request addr %08h required none", dbus_addr_o);
        end else begin
          mon_rq = req_q.pop_front();
          check("req_we", 32'(dbus_we_o), 32'(mon_rq.we));
          check("req_addr", dbus_addr_o, mon_rq.addr);
          if (mon_rq.we) begin
            check("req_be", 32'(dbus_be_o), 32'(mon_rq.be));
            check("req_wdata", dbus_wdata_o, mon_rq.wdata);
          end
        end
      end
      if (mon_acc && mem_stall_out) stall_cnt++;
      if (mon_acc && !mem_stall_out) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got retire required none at %0t", $time);
        end else begin
          mon_rs = rsp_q.pop_front();
          check("misalign", 32'(misalign_out), 32'(mon_rs.misal));
          check("stall_cycles", 32'(stall_cnt), 32'(mon_rs.stalls));
          if (mon_rs.misal) begin
            check("misalign_req", 32'(dbus_req_o), 32'd0);
          end else begin
            check("bus_err", 32'(bus_err_out), 32'(mon_rs.err));
            if (mon_rs.is_load) check("load_data", load_data_out, mon_rs.data);
          end
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit          r_rd, r_wr, r_nr;
  logic [2:0]  r_mask;
  logic [31:0] r_addr, r_wd, r_rdata;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(dbus_req_o), 32'd0);
    check("rst_stall", 32'(mem_stall_out), 32'd0);
    check("rst_load_data", load_data_out, 32'd0);
    check("rst_bus_err", 32'(bus_err_out), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    issue(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 1, 0, 32'h0);        // SW, no stall
    issue(0, 1, 3'b000, 32'h103, 32'h0000_00A5, 2, 1, 0, 32'h0);        // SB, 3 stalls
    issue(1, 0, 3'b000, 32'h102, 32'h0, 0, 1, 0, 32'h0080_FF00);        // LB
    issue(1, 0, 3'b100, 32'h102, 32'h0, 0, 1, 0, 32'h0080_FF00);        // LBU
    issue(1, 0, 3'b001, 32'h102, 32'h0, 1, 2, 0, 32'h8001_1234);        // LH
    idle(2);
    issue(1, 0, 3'b010, 32'h104, 32'h0, 0, 1, 1, 32'h0);                // LW timeout
    issue(1, 1, 3'b101, 32'h102, 32'h0, 0, 3, 0, 32'h8001_5678);        // LHU, read wins
    issue(1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 0, 32'h1357_9BDF);        // LW misaligned addr
    issue(0, 1, 3'b111, 32'h20A, 32'h1122_3344, 1, 1, 0, 32'h0);        // undefined mask -> W
    issue(1, 0, 3'b001, 32'h300, 32'h0, 0, 1, 0, 32'h0000_7FFF);        // LH positive

    // Reset while a load waits for data; a late rvalid must not update anything.
    mon_en        = 1'b0;
    mem_read_in   = 1'b1;
    mask_in       = 3'b010;
    alu_result_in = 32'h200;
    #1;
    dbus_gnt_i = 1'b1;
    @(posedge clk);
    #1;
    dbus_gnt_i = 1'b0;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    mem_read_in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("wait_rst_req", 32'(dbus_req_o), 32'd0);
    check("wait_rst_stall", 32'(mem_stall_out), 32'd0);
    check("wait_rst_load_data", load_data_out, 32'd0);
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h1234_5678;
    @(posedge clk);
    #1;
    dbus_rvalid_i = 1'b0;
    check("late_rvalid_load_data", load_data_out, 32'd0);
    check("late_rvalid_bus_err", 32'(bus_err_out), 32'd0);
    check("late_rvalid_stall", 32'(mem_stall_out), 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 250; i++) begin
      r_rd    = 1'($urandom_range(0, 1));
      r_wr    = r_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      r_mask  = 3'($urandom_range(0, 7));
      r_addr  = $urandom;
      r_wd    = $urandom;
      r_rdata = $urandom;
      r_nr    = ($urandom_range(0, 9) == 0);
      issue(r_rd, r_wr, r_mask, r_addr, r_wd, int'($urandom_range(0, 3)),
            int'($urandom_range(1, 3)), r_nr, r_rdata);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
